// File: rtl/avr_instruction_encoder.sv
// Assembles decoder opcode IDs plus operand fields into one or two AVR program words.
// Define ENC_RANGE_CHECK_EN to reject out-of-range operands instead of truncating them.
module avr_instruction_encoder #(
    parameter int ADDR_W  = 16,
    parameter int JMP_K_W = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        op_id,
    input  logic [4:0]        rd,
    input  logic [4:0]        rr,
    input  logic [21:0]       imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_value,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [15:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              enc_error
);

`ifdef ENC_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    localparam logic [7:0] OP_LDI  = 8'd1,  OP_ADD  = 8'd2,  OP_ADC  = 8'd3,  OP_SBC  = 8'd4;
    localparam logic [7:0] OP_CPC  = 8'd5,  OP_AND  = 8'd6,  OP_EOR  = 8'd7,  OP_OR   = 8'd8;
    localparam logic [7:0] OP_MOV  = 8'd9,  OP_CPSE = 8'd10, OP_CPI  = 8'd11, OP_SBCI = 8'd12;
    localparam logic [7:0] OP_SUBI = 8'd13, OP_ORI  = 8'd14, OP_ANDI = 8'd15, OP_COM  = 8'd16;
    localparam logic [7:0] OP_LSR  = 8'd17, OP_PUSH = 8'd19, OP_POP  = 8'd20, OP_IN   = 8'd21;
    localparam logic [7:0] OP_OUT  = 8'd22, OP_NOP  = 8'd23, OP_RET  = 8'd24, OP_RETI = 8'd25;
    localparam logic [7:0] OP_CLI  = 8'd26, OP_SEI  = 8'd27, OP_RJMP = 8'd29, OP_BREQ = 8'd30;
    localparam logic [7:0] OP_BRNE = 8'd31, OP_BRCC = 8'd32, OP_ADIW = 8'd33, OP_SBIW = 8'd34;
    localparam logic [7:0] OP_MOVW = 8'd35, OP_JMP  = 8'd36, OP_CALL = 8'd37, OP_LDS  = 8'd38;
    localparam logic [7:0] OP_STS  = 8'd43, OP_SUB  = 8'd45;

    typedef enum logic [1:0] {IDLE, WORD1, WORD2} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [15:0]       word2_q;
    logic [15:0]       enc_w1, enc_w2;
    logic              enc_two, known, bad, enc_ok;
    logic [21:0]       jmp_k;

    function automatic logic [15:0] fmt_rr(input logic [5:0] b, input logic [4:0] d, input logic [4:0] r);
        return {b, r[4], d, r[3:0]};
    endfunction

    function automatic logic [15:0] fmt_ri(input logic [3:0] b, input logic [4:0] d, input logic [7:0] k);
        return {b, k[7:4], d[3:0], k[3:0]};
    endfunction

    assign jmp_k = 22'(imm[JMP_K_W-1:0]);

    wire k8_bad    = |imm[21:8];
    wire k6_bad    = |imm[21:6];
    wire rel12_bad = !((&imm[21:11]) || !(|imm[21:11]));
    wire rel7_bad  = !((&imm[21:6]) || !(|imm[21:6]));
    wire pair_bad  = !(rd[4:3] == 2'b11 && !rd[0]);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        enc_w1  = '0;
        enc_w2  = '0;
        enc_two = 1'b0;
        known   = 1'b1;
        bad     = 1'b0;
        case (op_id)
            OP_AND:  enc_w1 = fmt_rr(6'b001000, rd, rr);
            OP_EOR:  enc_w1 = fmt_rr(6'b001001, rd, rr);
            OP_OR:   enc_w1 = fmt_rr(6'b001010, rd, rr);
            OP_MOV:  enc_w1 = fmt_rr(6'b001011, rd, rr);
            OP_CPC:  enc_w1 = fmt_rr(6'b000001, rd, rr);
            OP_CPSE: enc_w1 = fmt_rr(6'b000100, rd, rr);
            OP_SBC:  enc_w1 = fmt_rr(6'b000010, rd, rr);
            OP_ADD:  enc_w1 = fmt_rr(6'b000011, rd, rr);
            OP_SUB:  enc_w1 = fmt_rr(6'b000110, rd, rr);
            OP_ADC:  enc_w1 = fmt_rr(6'b000111, rd, rr);
            OP_CPI:  begin enc_w1 = fmt_ri(4'b0011, rd, imm[7:0]); bad = !rd[4] || k8_bad; end
            OP_SBCI: begin enc_w1 = fmt_ri(4'b0100, rd, imm[7:0]); bad = !rd[4] || k8_bad; end
            OP_SUBI: begin enc_w1 = fmt_ri(4'b0101, rd, imm[7:0]); bad = !rd[4] || k8_bad; end
            OP_ORI:  begin enc_w1 = fmt_ri(4'b0110, rd, imm[7:0]); bad = !rd[4] || k8_bad; end
            OP_ANDI: begin enc_w1 = fmt_ri(4'b0111, rd, imm[7:0]); bad = !rd[4] || k8_bad; end
            OP_LDI:  begin enc_w1 = fmt_ri(4'b1110, rd, imm[7:0]); bad = !rd[4] || k8_bad; end
            OP_COM:  enc_w1 = {7'b1001010, rd, 4'b0000};
            OP_LSR:  enc_w1 = {7'b1001010, rd, 4'b0110};
            OP_PUSH: enc_w1 = {7'b1001001, rd, 4'b1111};
            OP_POP:  enc_w1 = {7'b1001000, rd, 4'b1111};
            OP_IN:   begin enc_w1 = {5'b10110, imm[5:4], rd, imm[3:0]}; bad = k6_bad; end
            OP_OUT:  begin enc_w1 = {5'b10111, imm[5:4], rd, imm[3:0]}; bad = k6_bad; end
            OP_NOP:  enc_w1 = 16'h0000;
            OP_RET:  enc_w1 = 16'h9508;
            OP_RETI: enc_w1 = 16'h9518;
            OP_CLI:  enc_w1 = 16'h94F8;
            OP_SEI:  enc_w1 = 16'h9478;
            OP_RJMP: begin enc_w1 = {4'b1100, imm[11:0]}; bad = rel12_bad; end
            OP_BREQ: begin enc_w1 = {5'b11110, 1'b0, imm[6:0], 3'b001}; bad = rel7_bad; end
            OP_BRNE: begin enc_w1 = {5'b11110, 1'b1, imm[6:0], 3'b001}; bad = rel7_bad; end
            OP_BRCC: begin enc_w1 = {5'b11110, 1'b1, imm[6:0], 3'b000}; bad = rel7_bad; end
            OP_ADIW: begin enc_w1 = {8'b10010110, imm[5:4], rd[2:1], imm[3:0]}; bad = pair_bad || k6_bad; end
            OP_SBIW: begin enc_w1 = {8'b10010111, imm[5:4], rd[2:1], imm[3:0]}; bad = pair_bad || k6_bad; end
            OP_MOVW: begin enc_w1 = {8'b00000001, rd[4:1], rr[4:1]}; bad = rd[0] || rr[0]; end
            OP_JMP:  begin enc_w1 = {7'b1001010, jmp_k[21:17], 3'b110, jmp_k[16]}; enc_w2 = jmp_k[15:0]; enc_two = 1'b1; end
            OP_CALL: begin enc_w1 = {7'b1001010, jmp_k[21:17], 3'b111, jmp_k[16]}; enc_w2 = jmp_k[15:0]; enc_two = 1'b1; end
            OP_LDS:  begin enc_w1 = {7'b1001000, rd, 4'b0000}; enc_w2 = imm[15:0]; enc_two = 1'b1; end
            OP_STS:  begin enc_w1 = {7'b1001001, rd, 4'b0000}; enc_w2 = imm[15:0]; enc_two = 1'b1; end
            default: known = 1'b0;
        endcase
        enc_ok = known && !(RANGE_CHECK && bad);
    end

    assign in_ready = (state == IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_cnt   <= '0;
            word2_q    <= '0;
            word_valid <= 1'b0;
            out_word   <= '0;
            out_addr   <= '0;
            out_last   <= 1'b0;
            enc_error  <= 1'b0;
        end else begin
            enc_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (addr_load)
                        addr_cnt <= addr_value;
                    if (in_valid) begin
                        if (enc_ok) begin
                            out_word   <= enc_w1;
                            out_addr   <= addr_load ? addr_value : addr_cnt;
                            out_last   <= !enc_two;
                            word2_q    <= enc_w2;
                            word_valid <= 1'b1;
                            state      <= WORD1;
                        end else begin
                            enc_error <= 1'b1;
                        end
                    end
                end
                WORD1: if (word_ready) begin
                    addr_cnt <= addr_cnt + 1'b1;
                    if (out_last) begin
                        word_valid <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        out_word <= word2_q;
                        out_addr <= addr_cnt + 1'b1;
                        out_last <= 1'b1;
                        state    <= WORD2;
                    end
                end
                WORD2: if (word_ready) begin
                    addr_cnt   <= addr_cnt + 1'b1;
                    word_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avr_instruction_encoder.sv
// Directed bench for avr_instruction_encoder: expected words are queued at issue and
// compared by a monitor as each word handshake completes.
module tb_avr_instruction_encoder;

    localparam logic [7:0] OP_LDI = 8'd1,  OP_ADD = 8'd2,  OP_COM = 8'd16, OP_LD = 8'd18;
    localparam logic [7:0] OP_IN  = 8'd21, OP_NOP = 8'd23, OP_RET = 8'd24, OP_RJMP = 8'd29;
    localparam logic [7:0] OP_BRNE = 8'd31, OP_ADIW = 8'd33, OP_MOVW = 8'd35, OP_JMP = 8'd36;
    localparam logic [7:0] OP_CALL = 8'd37, OP_LDS = 8'd38, OP_STS = 8'd43, OP_SUB = 8'd45;

    typedef struct packed {
        logic [15:0] word;
        logic [15:0] addr;
        logic        last;
    } exp_t;

    typedef struct packed {
        logic [7:0]  op;
        logic [4:0]  d;
        logic [4:0]  r;
        logic [21:0] k;
        logic [15:0] w;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  op_id = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rr = '0;
    logic [21:0] imm = '0;
    logic        addr_load = 1'b0;
    logic [15:0] addr_value = '0;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [15:0] out_word;
    logic [15:0] out_addr;
    logic        out_last;
    logic        enc_error;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t e;
    vec_t vecs[7];
    logic [15:0] exp_addr;

    avr_instruction_encoder #(.ADDR_W(16), .JMP_K_W(22)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_id(op_id), .rd(rd), .rr(rr), .imm(imm),
        .addr_load(addr_load), .addr_value(addr_value),
        .word_valid(word_valid), .word_ready(word_ready),
        .out_word(out_word), .out_addr(out_addr), .out_last(out_last),
        .enc_error(enc_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completed word handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && word_valid && word_ready) begin
            check("word_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("out_word", out_word, e.word);
                check("out_addr", out_addr, e.addr);
                check("out_last", out_last, e.last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [15:0] w, input logic [15:0] a, input logic l);
        q.push_back('{word: w, addr: a, last: l});
    endtask

    task automatic send(input logic [7:0] op, input logic [4:0] d, input logic [4:0] r,
                        input logic [21:0] k, input logic ld);
        logic ok;
        ok = 1'b0;
        op_id = op; rd = d; rr = r; imm = k;
        in_valid = 1'b1;
        addr_load = ld;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        addr_load = 1'b0;
        check("accept", ok, 1);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (q.size() == 0 && !word_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check("drain", done, 1);
    endtask

    initial begin
        vecs[0] = '{op: OP_IN,   d: 5'd5,  r: 5'd0,  k: 22'h00003F, w: 16'hB65F};
        vecs[1] = '{op: OP_BRNE, d: 5'd0,  r: 5'd0,  k: 22'h3FFFFE, w: 16'hF7F1};
        vecs[2] = '{op: OP_MOVW, d: 5'd2,  r: 5'd4,  k: 22'h000000, w: 16'h0112};
        vecs[3] = '{op: OP_ADIW, d: 5'd26, r: 5'd0,  k: 22'h000011, w: 16'h9651};
        vecs[4] = '{op: OP_SUB,  d: 5'd31, r: 5'd31, k: 22'h000000, w: 16'h1BFF};
        vecs[5] = '{op: OP_COM,  d: 5'd0,  r: 5'd0,  k: 22'h000000, w: 16'h9400};
        vecs[6] = '{op: OP_RJMP, d: 5'd0,  r: 5'd0,  k: 22'h0007FF, w: 16'hC7FF};

        // Reset values
        tick(); tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_word_valid", word_valid, 0);
        check("rst_out_word", out_word, 16'h0000);
        check("rst_out_addr", out_addr, 16'h0000);
        check("rst_out_last", out_last, 0);
        check("rst_enc_error", enc_error, 0);
        reset = 1'b0;
        tick();

        // Load address, then a one-word ldi
        addr_load = 1'b1; addr_value = 16'h0100;
        tick();
        addr_load = 1'b0;
        word_ready = 1'b1;
        expect_word(16'hEA0B, 16'h0100, 1'b1);
        send(OP_LDI, 5'd16, 5'd0, 22'h0000AB, 1'b0);
        drain();

        // Two-word call with the sink stalled for three cycles
        word_ready = 1'b0;
        expect_word(16'h940E, 16'h0101, 1'b0);
        expect_word(16'h0123, 16'h0102, 1'b1);
        send(OP_CALL, 5'd0, 5'd0, 22'h000123, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", word_valid, 1);
            check("stall_word", out_word, 16'h940E);
            check("stall_addr", out_addr, 16'h0101);
            check("stall_in_ready", in_ready, 0);
            tick();
        end
        word_ready = 1'b1;
        drain();

        // Back-to-back add then ret
        expect_word(16'h0E11, 16'h0103, 1'b1);
        expect_word(16'h9508, 16'h0104, 1'b1);
        send(OP_ADD, 5'd1, 5'd17, 22'h0, 1'b0);
        check("add_in_ready_word1", in_ready, 0);
        send(OP_RET, 5'd0, 5'd0, 22'h0, 1'b0);
        check("ret_in_ready_word1", in_ready, 0);
        drain();

        // Unknown op (skip ID) is rejected; counter unchanged
        send(8'd156, 5'd0, 5'd0, 22'h0, 1'b0);
        check("unk_enc_error", enc_error, 1);
        check("unk_no_word", word_valid, 0);
        tick();
        check("unk_error_pulse_end", enc_error, 0);
        expect_word(16'h0000, 16'h0105, 1'b1);
        send(OP_NOP, 5'd0, 5'd0, 22'h0, 1'b0);
        drain();

        // Same-cycle addr_load + sts wrapping from 0xFFFF to 0x0000
        addr_value = 16'hFFFF;
        expect_word(16'h9250, 16'hFFFF, 1'b0);
        expect_word(16'h0060, 16'h0000, 1'b1);
        send(OP_STS, 5'd5, 5'd0, 22'h000060, 1'b1);
        drain();

        // addr_load during WORD1 is ignored
        word_ready = 1'b0;
        expect_word(16'h95FD, 16'h0001, 1'b0);
        expect_word(16'hFFFF, 16'h0002, 1'b1);
        send(OP_JMP, 5'd0, 5'd0, 22'h3FFFFF, 1'b0);
        addr_load = 1'b1; addr_value = 16'h1234;
        tick();
        addr_load = 1'b0;
        word_ready = 1'b1;
        drain();
        exp_addr = 16'h0003;

        // ldi with a low register
`ifdef ENC_RANGE_CHECK_EN
        send(OP_LDI, 5'd3, 5'd0, 22'h0000AB, 1'b0);
        check("ldi_r3_error", enc_error, 1);
        check("ldi_r3_no_word", word_valid, 0);
`else
        expect_word(16'hEA3B, exp_addr, 1'b1);
        send(OP_LDI, 5'd3, 5'd0, 22'h0000AB, 1'b0);
        exp_addr = exp_addr + 16'd1;
        drain();
`endif

        // Assorted encodings, all in range
        foreach (vecs[i]) begin
            expect_word(vecs[i].w, exp_addr, 1'b1);
            send(vecs[i].op, vecs[i].d, vecs[i].r, vecs[i].k, 1'b0);
            exp_addr = exp_addr + 16'd1;
        end
        drain();

        // Unimplemented ld follows the unknown path
        send(OP_LD, 5'd1, 5'd0, 22'h0, 1'b0);
        check("ld_enc_error", enc_error, 1);
        check("ld_no_word", word_valid, 0);
        expect_word(16'h0000, exp_addr, 1'b1);
        send(OP_NOP, 5'd0, 5'd0, 22'h0, 1'b0);
        drain();

        // Reset while a word is pending abandons it
        word_ready = 1'b0;
        send(OP_LDS, 5'd2, 5'd0, 22'h001234, 1'b0);
        check("pending_valid", word_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_word_valid", word_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_addr", out_addr, 16'h0000);
        check("queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
